// File: rtl/hazard_forward_unit.sv
// Decode-side hazard unit: shift-register scoreboard of in-flight writers driving bypass selects, load-use stalls and jump flushes.
// Outputs are combinational from scoreboard and decode inputs; in_EN=0 freezes all state, so a stall holds for as long as the pipe is frozen.
module hazard_forward_unit #(
    parameter int REG_AW   = 5,
    parameter int DEPTH    = 3,
    parameter int LOAD_LAT = 1,
    parameter bit FWD_EN   = 1'b1,
    parameter int SELW     = $clog2(DEPTH + 1),
    parameter int CNT_W    = 16
) (
    input  logic              in_CLK,
    input  logic              in_RST,
    input  logic              in_EN,
    input  logic              in_ID_VALID,
    input  logic [REG_AW-1:0] in_ID_RS,
    input  logic [REG_AW-1:0] in_ID_RT,
    input  logic              in_ID_USE_RS,
    input  logic              in_ID_USE_RT,
    input  logic              in_ID_WE,
    input  logic [REG_AW-1:0] in_ID_RD,
    input  logic              in_ID_LOAD,
    input  logic              in_JUMP,
    output logic              out_STALL,
    output logic              out_DECLR,
    output logic              out_FDCLR,
    output logic [SELW-1:0]   out_FWD_RS,
    output logic [SELW-1:0]   out_FWD_RT,
    output logic [CNT_W-1:0]  out_STALL_CNT
);

    typedef struct packed {
        logic              v;
        logic              we;
        logic [REG_AW-1:0] rd;
        logic              ld;
    } sb_ent_t;

    // Element k-1 holds stage k (1 = EX).
    sb_ent_t [DEPTH-1:0]      sb_q, sb_d;
    logic    [CNT_W-1:0]      cnt_q, cnt_d;

    logic [1:0][REG_AW-1:0]   src;
    logic [1:0]               src_use;
    logic [1:0]               src_hit;
    logic [1:0]               src_ok;
    logic [1:0][SELW-1:0]     src_stage;
    logic                     hazard;

    assign src[0]     = in_ID_RS;
    assign src[1]     = in_ID_RT;
    assign src_use[0] = in_ID_USE_RS;
    assign src_use[1] = in_ID_USE_RT;

    // Scan oldest to newest so the youngest matching producer is the one kept.
    always_comb begin
        src_hit   = '0;
        src_ok    = '0;
        src_stage = '0;
        for (int s = 0; s < 2; s++) begin
            for (int k = DEPTH; k >= 1; k--) begin
                if (sb_q[k-1].v && sb_q[k-1].we && (sb_q[k-1].rd == src[s]) &&
                    (src[s] != '0) && src_use[s]) begin
                    src_hit[s]   = 1'b1;
                    src_stage[s] = SELW'(k);
                    src_ok[s]    = FWD_EN && (!sb_q[k-1].ld || (k > LOAD_LAT));
                end
            end
        end
    end

    assign hazard     = in_ID_VALID && |(src_hit & ~src_ok);
    assign out_STALL  = hazard && !in_JUMP;
    assign out_DECLR  = out_STALL || in_JUMP;
    assign out_FDCLR  = in_JUMP;
    assign out_FWD_RS = (in_ID_VALID && !out_STALL && src_hit[0] && src_ok[0]) ? src_stage[0] : '0;
    assign out_FWD_RT = (in_ID_VALID && !out_STALL && src_hit[1] && src_ok[1]) ? src_stage[1] : '0;
    assign out_STALL_CNT = cnt_q;

    always_comb begin
        sb_d  = sb_q;
        cnt_d = cnt_q;
        if (in_EN) begin
            for (int k = DEPTH - 1; k >= 1; k--) begin
                sb_d[k] = sb_q[k-1];
            end
            // A stalled or squashed decode slot enters EX as a bubble.
            sb_d[0] = out_DECLR ? '0 : sb_ent_t'({in_ID_VALID, in_ID_WE, in_ID_RD, in_ID_LOAD});
            if (out_STALL && !(&cnt_q)) begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge in_CLK or posedge in_RST) begin
        if (in_RST) begin
            sb_q  <= '0;
            cnt_q <= '0;
        end else begin
            sb_q  <= sb_d;
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: tb/tb_hazard_forward_unit.sv
// Randomised and directed bench for hazard_forward_unit with bypass on and off, checked against an in-flight-list model.
module tb_hazard_forward_unit;

    localparam int AW    = 5;
    localparam int DEPTH = 3;
    localparam int LL    = 1;
    localparam int SELW  = 2;
    localparam int CNT_W = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst, en, valid, use_rs, use_rt, we, ld, jump;
    logic [AW-1:0] rs, rt, rd;

    logic [1:0]           stall_o, declr_o, fdclr_o;
    logic [SELW-1:0]      fwdrs_o [2];
    logic [SELW-1:0]      fwdrt_o [2];
    logic [CNT_W-1:0]     cnt_o   [2];

    hazard_forward_unit #(.FWD_EN(1'b1)) u_fwd (
        .in_CLK(clk), .in_RST(rst), .in_EN(en), .in_ID_VALID(valid),
        .in_ID_RS(rs), .in_ID_RT(rt), .in_ID_USE_RS(use_rs), .in_ID_USE_RT(use_rt),
        .in_ID_WE(we), .in_ID_RD(rd), .in_ID_LOAD(ld), .in_JUMP(jump),
        .out_STALL(stall_o[0]), .out_DECLR(declr_o[0]), .out_FDCLR(fdclr_o[0]),
        .out_FWD_RS(fwdrs_o[0]), .out_FWD_RT(fwdrt_o[0]), .out_STALL_CNT(cnt_o[0])
    );

    hazard_forward_unit #(.FWD_EN(1'b0)) u_nofwd (
        .in_CLK(clk), .in_RST(rst), .in_EN(en), .in_ID_VALID(valid),
        .in_ID_RS(rs), .in_ID_RT(rt), .in_ID_USE_RS(use_rs), .in_ID_USE_RT(use_rt),
        .in_ID_WE(we), .in_ID_RD(rd), .in_ID_LOAD(ld), .in_JUMP(jump),
        .out_STALL(stall_o[1]), .out_DECLR(declr_o[1]), .out_FDCLR(fdclr_o[1]),
        .out_FWD_RS(fwdrs_o[1]), .out_FWD_RT(fwdrt_o[1]), .out_STALL_CNT(cnt_o[1])
    );

    typedef struct packed {
        logic          rst, en, valid, use_rs, use_rt, we, ld, jump;
        logic [AW-1:0] rs, rt, rd;
    } in_t;

    typedef struct packed {
        logic          v, we;
        logic [AW-1:0] rd;
        logic          ld;
    } ent_t;

    typedef struct packed {
        logic [1:0]             stall, declr, fdclr;
        logic [1:0][SELW-1:0]   fwdrs, fwdrt;
        logic [1:0][CNT_W-1:0]  cnt;
    } exp_t;

    exp_t q[$];
    ent_t mdl [2][DEPTH];
    int   mcnt [2];
    int   n_chk  = 0;
    int   n_fail = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void model_clear();
        for (int d = 0; d < 2; d++) begin
            mcnt[d] = 0;
            for (int a = 0; a < DEPTH; a++) mdl[d][a] = '0;
        end
    endfunction

    // Age (1 = youngest) of the youngest in-flight writer of s, 0 if none.
    function automatic int newest(input int d, input logic [AW-1:0] s, input logic u);
        for (int a = 0; a < DEPTH; a++) begin
            if (u && s != 0 && mdl[d][a].v && mdl[d][a].we && mdl[d][a].rd == s) return a + 1;
        end
        return 0;
    endfunction

    function automatic in_t mk(input logic v, input int s_rs, input int s_rt, input logic urs,
                               input logic urt, input logic w, input int d_rd, input logic l,
                               input logic j);
        in_t x;
        x = '0;
        x.en = 1'b1; x.valid = v; x.rs = AW'(s_rs); x.rt = AW'(s_rt);
        x.use_rs = urs; x.use_rt = urt; x.we = w; x.rd = AW'(d_rd); x.ld = l; x.jump = j;
        return x;
    endfunction

    task automatic drive(input in_t x);
        exp_t e;
        int   ars, art;
        bit   ok_rs, ok_rt, hz;
        bit   st [2];
        @(posedge clk);
        #1;
        rst = x.rst; en = x.en; valid = x.valid; rs = x.rs; rt = x.rt;
        use_rs = x.use_rs; use_rt = x.use_rt; we = x.we; rd = x.rd; ld = x.ld; jump = x.jump;
        if (x.rst) model_clear();
        e = '0;
        for (int d = 0; d < 2; d++) begin
            ars   = newest(d, x.rs, x.use_rs);
            art   = newest(d, x.rt, x.use_rt);
            ok_rs = (d == 0) && ars > 0 && (!mdl[d][(ars > 0) ? ars - 1 : 0].ld || ars > LL);
            ok_rt = (d == 0) && art > 0 && (!mdl[d][(art > 0) ? art - 1 : 0].ld || art > LL);
            hz    = x.valid && ((ars > 0 && !ok_rs) || (art > 0 && !ok_rt));
            st[d] = hz && !x.jump;
            e.stall[d] = st[d];
            e.declr[d] = st[d] || x.jump;
            e.fdclr[d] = x.jump;
            e.fwdrs[d] = (x.valid && !st[d] && ok_rs) ? SELW'(ars) : '0;
            e.fwdrt[d] = (x.valid && !st[d] && ok_rt) ? SELW'(art) : '0;
            e.cnt[d]   = CNT_W'(mcnt[d]);
        end
        q.push_back(e);
        if (!x.rst && x.en) begin
            for (int d = 0; d < 2; d++) begin
                if (st[d] && mcnt[d] < 65535) mcnt[d]++;
                for (int a = DEPTH - 1; a >= 1; a--) mdl[d][a] = mdl[d][a-1];
                mdl[d][0] = (st[d] || x.jump) ? '0 : ent_t'({x.valid, x.we, x.rd, x.ld});
            end
        end
    endtask

    task automatic do_reset();
        in_t x;
        x = mk(0, 0, 0, 0, 0, 0, 0, 0, 0);
        x.rst = 1'b1;
        drive(x);
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (q.size() > 0) begin
            e = q.pop_front();
            for (int d = 0; d < 2; d++) begin
                chk($sformatf("stall[%0d]", d), int'(stall_o[d]), int'(e.stall[d]));
                chk($sformatf("declr[%0d]", d), int'(declr_o[d]), int'(e.declr[d]));
                chk($sformatf("fdclr[%0d]", d), int'(fdclr_o[d]), int'(e.fdclr[d]));
                chk($sformatf("fwd_rs[%0d]", d), int'(fwdrs_o[d]), int'(e.fwdrs[d]));
                chk($sformatf("fwd_rt[%0d]", d), int'(fwdrt_o[d]), int'(e.fwdrt[d]));
                chk($sformatf("cnt[%0d]", d), int'(cnt_o[d]), int'(e.cnt[d]));
            end
        end
    end

    initial begin
        in_t x;
        rst = 1'b1; en = 1'b0; valid = 1'b0; use_rs = 1'b0; use_rt = 1'b0;
        we = 1'b0; ld = 1'b0; jump = 1'b0; rs = '0; rt = '0; rd = '0;
        model_clear();
        do_reset();
        do_reset();

        // ALU producer forwarded from EX, then from MEM across a gap instruction.
        drive(mk(1, 1, 2, 1, 1, 1, 3, 0, 0));
        drive(mk(1, 3, 0, 1, 0, 0, 0, 0, 0));
        do_reset();
        drive(mk(1, 1, 2, 1, 1, 1, 3, 0, 0));
        drive(mk(1, 1, 0, 1, 0, 0, 0, 0, 0));
        drive(mk(1, 3, 0, 1, 0, 0, 0, 0, 0));

        // Load-use on rt: one stall, then MEM bypass.
        do_reset();
        drive(mk(1, 0, 0, 0, 0, 1, 4, 1, 0));
        drive(mk(1, 0, 4, 0, 1, 0, 0, 0, 0));
        drive(mk(1, 0, 4, 0, 1, 0, 0, 0, 0));
        drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 0));
        chk("loaduse_cnt", int'(cnt_o[0]), 1);

        // Jump overrides a load-use stall; the squashed slot becomes a bubble.
        do_reset();
        drive(mk(1, 0, 0, 0, 0, 1, 5, 1, 0));
        drive(mk(1, 5, 0, 1, 0, 1, 9, 0, 1));
        drive(mk(1, 5, 9, 1, 1, 0, 0, 0, 0));

        // $0 is never a hazard; youngest of two $6 writers wins.
        do_reset();
        drive(mk(1, 0, 0, 0, 0, 1, 0, 0, 0));
        drive(mk(1, 0, 0, 1, 1, 0, 0, 0, 0));
        drive(mk(1, 0, 0, 0, 0, 1, 6, 0, 0));
        drive(mk(1, 0, 0, 0, 0, 1, 6, 0, 0));
        drive(mk(1, 6, 6, 1, 1, 0, 0, 0, 0));

        // Without bypass the consumer waits for the producer to leave the scoreboard.
        do_reset();
        drive(mk(1, 0, 0, 0, 0, 1, 7, 0, 0));
        repeat (4) drive(mk(1, 7, 0, 1, 0, 0, 0, 0, 0));
        drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 0));
        chk("nofwd_cnt", int'(cnt_o[1]), 3);

        // Frozen pipe during a load-use stall, then asynchronous reset mid-stall.
        do_reset();
        drive(mk(1, 0, 0, 0, 0, 1, 4, 1, 0));
        x = mk(1, 0, 4, 0, 1, 0, 0, 0, 0);
        x.en = 1'b0;
        repeat (4) drive(x);
        drive(mk(1, 0, 4, 0, 1, 0, 0, 0, 0));
        drive(x);
        @(negedge clk);
        #2;
        chk("pre_rst_stall", int'(stall_o[1]), 1);
        chk("pre_rst_cnt", int'(cnt_o[1]), 1);
        rst = 1'b1;
        #1;
        model_clear();
        chk("async_rst_stall0", int'(stall_o[0]), 0);
        chk("async_rst_stall1", int'(stall_o[1]), 0);
        chk("async_rst_cnt0", int'(cnt_o[0]), 0);
        chk("async_rst_cnt1", int'(cnt_o[1]), 0);
        drive(mk(1, 0, 4, 0, 1, 0, 0, 0, 0));

        // Random traffic over a small register window to provoke dependences.
        for (int i = 0; i < 500; i++) begin
            x = mk($urandom_range(0, 7) != 0, $urandom_range(0, 7), $urandom_range(0, 7),
                   $urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0,
                   $urandom_range(0, 3) != 0, $urandom_range(0, 7),
                   $urandom_range(0, 9) < 3, $urandom_range(0, 99) < 8);
            x.en  = $urandom_range(0, 9) != 0;
            x.rst = $urandom_range(0, 149) == 0;
            drive(x);
        end

        repeat (2) @(negedge clk);
        #1;
        chk("queue_drained", q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
